// File: rtl/uart_tx_sched_pkg.sv
// Shared types and helpers for the uart_tx_sched scheduler.
// Holds the FSM state encoding, the default byte width and the round-robin wrap helper.
// No ports; imported by the arbiter and the top.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int DEF_DW = 8;

  // Index following idx in a ring of n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bundle of requester-side and serializer-side signals of uart_tx_sched.
// slave: the scheduler (takes valid/data/last/done, drives ready/tx_req/tx_data/grant/busy).
// master: the environment (requesters plus uart_tx), directions mirrored.
interface uart_tx_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ*DW-1:0] req_data_i;
  logic [NREQ-1:0]    req_last_i;
  logic [NREQ-1:0]    req_ready_o;
  logic               tx_req_o;
  logic [DW-1:0]      tx_data_o;
  logic               tx_done_i;
  logic [NREQ-1:0]    grant_o;
  logic               busy_o;

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_done_i,
    output req_ready_o, tx_req_o, tx_data_o, grant_o, busy_o
  );

  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_done_i,
    input  req_ready_o, tx_req_o, tx_data_o, grant_o, busy_o
  );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Rotate-priority arbiter: lowest requesting index at or above ptr, wrapping mod NREQ.
// Latency: purely combinational. Backpressure: none, it only picks a winner.
// Ports: req (requests), ptr (priority start) -> gnt (one-hot), idx (winner index), any (a winner exists).
module uart_tx_sched_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int          cand;
  logic [PW-1:0] cand_w;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    cand_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_w = PW'(cand);
      if (!any && req[cand_w]) begin
        any         = 1'b1;
        idx         = cand_w;
        gnt[cand_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx serializer between NREQ byte-stream requesters.
// Latency: valid in IDLE -> ready pulse next clock -> tx_req 2 clocks later; locked stream GAP_CYC+2 from done.
// Backpressure: a requester holds valid/data/last until its 1-cycle ready pulse; bytes wait while a frame runs.
// Ports: clk_i, reset_i (async, active-high); bus (slave) carries req_valid/data/last/ready, tx_req/data/done, grant, busy.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = DEF_DW,
  parameter int GAP_CYC   = 2,
  parameter int STALL_CYC = 1024
) (
  input  logic           clk_i,
  input  logic           reset_i,
  uart_tx_sched_if.slave bus
);

  localparam int PW = $clog2(NREQ);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int SW = $clog2(STALL_CYC + 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            lock_q, lock_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ready_q, ready_d;
  logic            tx_req_q, tx_req_d;
  logic [DW-1:0]   data_q, data_d;
  logic            busy_q, busy_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            done_q;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;
  logic            owner_vld;
  logic            done_rise;
  logic [PW-1:0]   ptr_after_owner;

  uart_tx_sched_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req (bus.req_valid_i),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign owner_vld       = bus.req_valid_i[owner_q];
  // Edge detect makes a level-style done count exactly once per frame.
  assign done_rise       = bus.tx_done_i & ~done_q;
  assign ptr_after_owner = PW'(rr_next(32'(owner_q), NREQ));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    lock_d   = lock_q;
    grant_d  = grant_q;
    ready_d  = '0;
    tx_req_d = tx_req_q;
    data_d   = data_q;
    gap_d    = gap_q;
    stall_d  = stall_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!lock_q) begin
          stall_d = '0;
          if (arb_any) begin
            owner_d = arb_idx;
            grant_d = arb_gnt;
            ready_d = arb_gnt;
            state_d = ST_GRANT;
          end
        end else if (owner_vld) begin
          // Locked packet resumes: only the owner may continue.
          stall_d = '0;
          ready_d = grant_q;
          state_d = ST_GRANT;
        end else if (stall_q == SW'(STALL_CYC - 1)) begin
          // Owner went quiet too long: abandon the packet and move priority past it.
          lock_d  = 1'b0;
          stall_d = '0;
          ptr_d   = ptr_after_owner;
          grant_d = '0;
        end else begin
          stall_d = stall_q + SW'(1);
        end
      end
      ST_GRANT: begin
        data_d   = bus.req_data_i[owner_q*DW +: DW];
        lock_d   = ~bus.req_last_i[owner_q];
        stall_d  = '0;
        tx_req_d = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (done_rise) begin
          tx_req_d = 1'b0;
          gap_d    = '0;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          gap_d = '0;
          if (lock_q && owner_vld) begin
            ready_d = grant_q;
            state_d = ST_GRANT;
          end else if (lock_q) begin
            state_d = ST_IDLE;
          end else begin
            ptr_d   = ptr_after_owner;
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      lock_q   <= 1'b0;
      grant_q  <= '0;
      ready_q  <= '0;
      tx_req_q <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      gap_q    <= '0;
      stall_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      lock_q   <= lock_d;
      grant_q  <= grant_d;
      ready_q  <= ready_d;
      tx_req_q <= tx_req_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      gap_q    <= gap_d;
      stall_q  <= stall_d;
      done_q   <= bus.tx_done_i;
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.tx_req_o    = tx_req_q;
  assign bus.tx_data_o   = data_q;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queued requester models, a uart_tx done responder, frame/ready monitors.
// Latency: n/a. Backpressure: requester models hold each byte until its ready pulse.
module tb_uart_tx_sched;

  localparam int NREQ     = 4;
  localparam int DW       = 8;
  localparam int GAP      = 2;
  localparam int STALL    = 1024;
  localparam int DONE_LAT = 4;

  logic clk = 1'b0;
  logic rst;

  uart_tx_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

  uart_tx_sched #(.NREQ(NREQ), .DW(DW), .GAP_CYC(GAP), .STALL_CYC(STALL)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [8:0] byte_q_t [$];
  byte_q_t    src [NREQ];
  logic [7:0] frames [$];
  int         rdy_idx [$];
  int         rdy_cyc [$];
  int         lat [$];
  int         done_cyc = 0;
  bit         resp_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    src[k].push_back({l, d});
  endtask

  task automatic clear_logs();
    frames.delete();
    rdy_idx.delete();
    rdy_cyc.delete();
    lat.delete();
  endtask

  function automatic bit pending();
    for (int k = 0; k < NREQ; k++) if (src[k].size() > 0) return 1'b1;
    return bus.busy_o;
  endfunction

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pending()) timeout_fail(name);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rdy(input string name, input int cnt, input int budget);
    int n;
    n = 0;
    while (rdy_idx.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rdy_idx.size() < cnt) timeout_fail(name);
  endtask

  // Requester models: present queue heads, pop after the posedge that took the byte.
  initial begin
    logic [NREQ-1:0] rs;
    logic [8:0]      h;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_last_i  = '0;
    forever begin
      @(negedge clk);
      rs = bus.req_ready_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (rs[k] && src[k].size() > 0) void'(src[k].pop_front());
        if (src[k].size() > 0) begin
          h = src[k][0];
          bus.req_valid_i[k]         = 1'b1;
          bus.req_data_i[k*DW +: DW] = h[7:0];
          bus.req_last_i[k]          = h[8];
        end else begin
          bus.req_valid_i[k]         = 1'b0;
          bus.req_data_i[k*DW +: DW] = '0;
          bus.req_last_i[k]          = 1'b0;
        end
      end
    end
  end

  // uart_tx stand-in: done pulse after DONE_LAT cycles of tx_req.
  initial begin
    int n;
    n = 0;
    bus.tx_done_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done_i = 1'b0;
      if (resp_en && !rst && bus.tx_req_o) begin
        n++;
        if (n == DONE_LAT) begin
          bus.tx_done_i = 1'b1;
          done_cyc = cyc;
          n = 0;
        end
      end else begin
        n = 0;
      end
    end
  end

  // Monitors: grant/ready shape, frame capture, data stability, inter-frame gap.
  initial begin
    logic            prev_req;
    logic [NREQ-1:0] prev_rdy;
    logic [DW-1:0]   held;
    int              low_run;
    bit              seen;
    prev_req = 1'b0; prev_rdy = '0; held = '0; low_run = 0; seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
        low_run = 0;
      end else begin
        if (bus.grant_o != '0) check("grant_onehot", 32'($onehot(bus.grant_o)), 1);
        if (bus.req_ready_o != '0) begin
          check("ready_onehot", 32'($onehot(bus.req_ready_o)), 1);
          check("ready_single_cycle", 32'(prev_rdy), 0);
          for (int k = 0; k < NREQ; k++) if (bus.req_ready_o[k]) rdy_idx.push_back(k);
          rdy_cyc.push_back(cyc);
        end
        if (bus.tx_req_o && !prev_req) begin
          frames.push_back(bus.tx_data_o);
          lat.push_back(cyc - done_cyc);
          held = bus.tx_data_o;
          if (seen) check("gap_min", 32'(low_run >= GAP), 1);
          seen = 1'b1;
        end else if (bus.tx_req_o && prev_req) begin
          check("tx_data_stable", 32'(bus.tx_data_o), 32'(held));
        end
        low_run = bus.tx_req_o ? 0 : low_run + 1;
      end
      prev_req = bus.tx_req_o;
      prev_rdy = bus.req_ready_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] vmask;
    logic [7:0] data [4];
    int         n;
    int         order [4];
  } vec_t;

  vec_t vecs [7];
  int   t4_order [8];

  initial begin
    // rr pointer is 0 at the first entry; each line lists the grant order worked out by hand.
    vecs[0] = '{vmask: 4'b0011, data: '{8'h95, 8'h14, 8'h00, 8'h00}, n: 2, order: '{0, 1, 0, 0}};
    vecs[1] = '{vmask: 4'b1010, data: '{8'h00, 8'h21, 8'h00, 8'h23}, n: 2, order: '{3, 1, 0, 0}};
    vecs[2] = '{vmask: 4'b0011, data: '{8'h30, 8'h31, 8'h00, 8'h00}, n: 2, order: '{0, 1, 0, 0}};
    vecs[3] = '{vmask: 4'b0100, data: '{8'h00, 8'h00, 8'h42, 8'h00}, n: 1, order: '{2, 0, 0, 0}};
    vecs[4] = '{vmask: 4'b1101, data: '{8'h50, 8'h00, 8'h52, 8'h53}, n: 3, order: '{3, 0, 2, 0}};
    vecs[5] = '{vmask: 4'b1111, data: '{8'h60, 8'h61, 8'h62, 8'h63}, n: 4, order: '{3, 0, 1, 2}};
    vecs[6] = '{vmask: 4'b1000, data: '{8'h00, 8'h00, 8'h00, 8'h73}, n: 1, order: '{3, 0, 0, 0}};
    t4_order = '{0, 1, 2, 3, 0, 1, 2, 3};

    // 1. reset with every requester valid, then first grant and tx_req timing.
    rst = 1'b1;
    for (int k = 0; k < NREQ; k++) push(k, 8'h10 + 8'(k), 1'b1);
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(bus.grant_o), 0);
    check("rst_ready", 32'(bus.req_ready_o), 0);
    check("rst_tx_req", 32'(bus.tx_req_o), 0);
    check("rst_tx_data", 32'(bus.tx_data_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    clear_logs();
    rst = 1'b0;
    @(posedge clk); #1;
    check("t1_ready_req0", 32'(bus.req_ready_o), 32'h1);
    check("t1_grant_req0", 32'(bus.grant_o), 32'h1);
    check("t1_tx_req_not_yet", 32'(bus.tx_req_o), 0);
    check("t1_busy", 32'(bus.busy_o), 1);
    @(posedge clk); #1;
    check("t1_tx_req_plus2", 32'(bus.tx_req_o), 1);
    check("t1_tx_data", 32'(bus.tx_data_o), 32'h10);
    wait_drain("t1_drain", 400);
    check("t1_frame_count", frames.size(), 4);
    for (int i = 0; i < 4 && i < frames.size(); i++) begin
      check("t1_frame", 32'(frames[i]), 32'h10 + i);
      check("t1_ready_order", rdy_idx[i], i);
    end

    // 2. table: single-byte packets from several requesters, rotation order.
    for (int v = 0; v < 7; v++) begin
      clear_logs();
      for (int k = 0; k < NREQ; k++) if (vecs[v].vmask[k]) push(k, vecs[v].data[k], 1'b1);
      wait_drain("tbl_drain", 400);
      check("tbl_frame_count", frames.size(), vecs[v].n);
      check("tbl_ready_count", rdy_idx.size(), vecs[v].n);
      for (int i = 0; i < vecs[v].n && i < frames.size() && i < rdy_idx.size(); i++) begin
        check("tbl_ready_order", rdy_idx[i], vecs[v].order[i]);
        check("tbl_frame_data", 32'(frames[i]), 32'(vecs[v].data[vecs[v].order[i]]));
      end
    end

    // 4. all requesters continuously valid, two bytes each: 0,1,2,3,0,1,2,3.
    clear_logs();
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < NREQ; k++) push(k, 8'h80 + 8'(16 * k + j), 1'b1);
    wait_drain("t4_drain", 800);
    check("t4_frame_count", frames.size(), 8);
    for (int i = 0; i < 8 && i < frames.size() && i < rdy_idx.size(); i++) begin
      check("t4_ready_order", rdy_idx[i], t4_order[i]);
      check("t4_frame_data", 32'(frames[i]), 32'h80 + 16 * t4_order[i] + i / 4);
    end

    // 3. locked 3-byte packet from req2 while req0 waits.
    clear_logs();
    push(2, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b0);
    push(2, 8'hA3, 1'b1);
    wait_rdy("t3_first_ready", 1, 50);
    push(0, 8'h55, 1'b1);
    wait_drain("t3_drain", 400);
    check("t3_frame_count", frames.size(), 4);
    if (frames.size() == 4 && rdy_idx.size() == 4) begin
      check("t3_f0", 32'(frames[0]), 32'hA1);
      check("t3_f1", 32'(frames[1]), 32'hA2);
      check("t3_f2", 32'(frames[2]), 32'hA3);
      check("t3_f3", 32'(frames[3]), 32'h55);
      check("t3_r2", rdy_idx[2], 2);
      check("t3_r3", rdy_idx[3], 0);
      check("t3_locked_lat1", lat[1], GAP + 2);
      check("t3_locked_lat2", lat[2], GAP + 2);
      check("t3_unlocked_lat", lat[3], GAP + 3);
    end

    // 5. req1 locks then goes quiet; req3 only wins after the stall timeout.
    clear_logs();
    push(1, 8'h77, 1'b0);
    wait_rdy("t5_first_ready", 1, 50);
    push(3, 8'h33, 1'b1);
    repeat (STALL / 2) @(negedge clk);
    check("t5_mid_grant_held", 32'(bus.grant_o), 32'h2);
    check("t5_mid_busy", 32'(bus.busy_o), 0);
    check("t5_mid_no_ready", rdy_idx.size(), 1);
    wait_rdy("t5_second_ready", 2, STALL + 100);
    if (rdy_idx.size() >= 2) begin
      check("t5_winner_req3", rdy_idx[1], 3);
      check("t5_stall_window",
            32'((rdy_cyc[1] - done_cyc) >= STALL && (rdy_cyc[1] - done_cyc) <= STALL + 8), 1);
    end
    wait_drain("t5_drain", 200);
    check("t5_frame_count", frames.size(), 2);
    if (frames.size() == 2) check("t5_second_frame", 32'(frames[1]), 32'h33);

    // 6. reset in the middle of sending 0x5A; nothing is resent afterwards.
    resp_en = 1'b0;
    clear_logs();
    push(2, 8'h5A, 1'b1);
    begin
      int n;
      n = 0;
      while (!bus.tx_req_o && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!bus.tx_req_o) timeout_fail("t6_send_start");
    end
    repeat (3) @(negedge clk);
    check("t6_sending_5a", 32'(bus.tx_data_o), 32'h5A);
    rst = 1'b1;
    #1;
    check("t6_tx_req_drops", 32'(bus.tx_req_o), 0);
    check("t6_grant_cleared", 32'(bus.grant_o), 0);
    repeat (2) @(negedge clk);
    resp_en = 1'b1;
    clear_logs();
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_no_resend", frames.size(), 0);
    check("t6_no_ready", rdy_idx.size(), 0);
    check("t6_idle", 32'(bus.busy_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
